// File: rtl/img_stream_pkg.sv
// Shared types, default geometry and helper functions for the image stream source.
package img_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HBLANK,
    ACTIVE,
    VTAIL,
    END,
    GAP
  } state_t;

  localparam int C_PIX_W            = 8;
  localparam int C_DEF_IMG_WIDTH    = 640;
  localparam int C_DEF_IMG_HEIGHT   = 480;
  localparam int C_DEF_H_BLANK      = 5;
  localparam int C_DEF_V_TAIL       = 5;
  localparam int C_DEF_FRAME_GAP    = 16;
  localparam int C_DEF_ADDR_W       = 19;

  // Number of cycles per_img_vsync stays high for one frame.
  function automatic int frame_vsync_cycles(input int w, input int h, input int hb, input int vt);
    return h * (hb + w) + vt;
  endfunction

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/img_stream_timing.sv
// Frame sequencer: walks blank/active/tail/gap phases and generates the
// linear read address, internal vsync, pre-href and the frame_done pulse.
module img_stream_timing
  import img_stream_pkg::*;
#(
  parameter int C_IMG_WIDTH  = C_DEF_IMG_WIDTH,
  parameter int C_IMG_HEIGHT = C_DEF_IMG_HEIGHT,
  parameter int C_H_BLANK    = C_DEF_H_BLANK,
  parameter int C_V_TAIL     = C_DEF_V_TAIL,
  parameter int C_FRAME_GAP  = C_DEF_FRAME_GAP,
  parameter int C_ADDR_W     = C_DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_cont,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_vsync,
  output logic                o_pre_href,
  output logic [C_ADDR_W-1:0] o_addr
);

  localparam int C_CNT_MAX = max_of4(C_IMG_WIDTH, C_H_BLANK, C_V_TAIL, C_FRAME_GAP);
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam int C_ROW_W   = $clog2(C_IMG_HEIGHT + 1);

  localparam logic [C_CNT_W-1:0] C_HB_LAST  = C_CNT_W'(C_H_BLANK - 1);
  localparam logic [C_CNT_W-1:0] C_ACT_LAST = C_CNT_W'(C_IMG_WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_VT_LAST  = C_CNT_W'(C_V_TAIL - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST = C_CNT_W'(C_FRAME_GAP - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(C_IMG_HEIGHT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_ROW_W-1:0]    r_row;
  logic [C_ADDR_W-1:0]   r_pix;
  logic [C_ADDR_W-1:0]   r_addr_hold;
  logic                  w_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_nxt = HBLANK;
      HBLANK:  if (r_cnt == C_HB_LAST) w_state_nxt = ACTIVE;
      ACTIVE:  if (r_cnt == C_ACT_LAST) w_state_nxt = (r_row == C_ROW_LAST) ? VTAIL : HBLANK;
      VTAIL:   if (r_cnt == C_VT_LAST) w_state_nxt = END;
      END:     w_state_nxt = i_cont ? GAP : IDLE;
      GAP:     if (r_cnt == C_GAP_LAST) w_state_nxt = HBLANK;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_frame_start = ((r_state == IDLE) || (r_state == GAP)) && (w_state_nxt == HBLANK);

  // One phase counter shared by every timed state; it restarts on each state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_row       <= '0;
      r_pix       <= '0;
      r_addr_hold <= '0;
    end else begin
      if ((r_state == IDLE) || (w_state_nxt != r_state)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == IDLE) || (r_state == GAP)) begin
        r_row <= '0;
        r_pix <= '0;
        if (w_frame_start) begin
          r_addr_hold <= '0;
        end
      end else if (r_state == ACTIVE) begin
        r_pix       <= r_pix + 1'b1;
        r_addr_hold <= r_pix;
        if (w_state_nxt == HBLANK) begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  assign o_vsync      = (r_state == HBLANK) || (r_state == ACTIVE) || (r_state == VTAIL);
  assign o_pre_href   = (r_state == ACTIVE);
  assign o_frame_done = (r_state == END);
  assign o_busy       = (r_state != IDLE);
  assign o_addr       = (r_state == ACTIVE) ? r_pix : r_addr_hold;

endmodule

// File: rtl/img_stream_src.sv
// Frame-to-stream transmitter: sequences ROM reads and re-times them onto the
// per_img_vsync/href/gray video interface through a two-stage alignment pipeline.
module img_stream_src
  import img_stream_pkg::*;
#(
  parameter int C_IMG_WIDTH  = C_DEF_IMG_WIDTH,
  parameter int C_IMG_HEIGHT = C_DEF_IMG_HEIGHT,
  parameter int C_H_BLANK    = C_DEF_H_BLANK,
  parameter int C_V_TAIL     = C_DEF_V_TAIL,
  parameter int C_FRAME_GAP  = C_DEF_FRAME_GAP,
  parameter int C_ADDR_W     = C_DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  output logic                busy,
  output logic                frame_done,
  output logic                mem_rd_en,
  output logic [C_ADDR_W-1:0] mem_rd_addr,
  input  logic [C_PIX_W-1:0]  mem_rd_data,
  output logic                per_img_vsync,
  output logic                per_img_href,
  output logic [C_PIX_W-1:0]  per_img_gray
);

  logic               w_vsync_p0;
  logic               w_href_p0;
  logic               w_busy_fsm;
  logic               w_start;
  logic               r_vsync_p1;
  logic               r_href_p1;
  logic               r_vsync_p2;
  logic               r_href_p2;
  logic [C_PIX_W-1:0] r_gray_p2;

  // The sequencer returns to IDLE two cycles before the video outputs drain;
  // a start arriving in that window is still "while busy" and is dropped.
  assign w_start = start & ~r_vsync_p1 & ~r_vsync_p2;

  img_stream_timing #(
    .C_IMG_WIDTH  (C_IMG_WIDTH),
    .C_IMG_HEIGHT (C_IMG_HEIGHT),
    .C_H_BLANK    (C_H_BLANK),
    .C_V_TAIL     (C_V_TAIL),
    .C_FRAME_GAP  (C_FRAME_GAP),
    .C_ADDR_W     (C_ADDR_W)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_cont       (cont),
    .o_busy       (w_busy_fsm),
    .o_frame_done (frame_done),
    .o_vsync      (w_vsync_p0),
    .o_pre_href   (w_href_p0),
    .o_addr       (mem_rd_addr)
  );

  assign mem_rd_en = w_href_p0;

  // p1: ROM read latency; p2: output register with gray gated by p1 href.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_p1 <= 1'b0;
      r_href_p1  <= 1'b0;
      r_vsync_p2 <= 1'b0;
      r_href_p2  <= 1'b0;
      r_gray_p2  <= '0;
    end else begin
      r_vsync_p1 <= w_vsync_p0;
      r_href_p1  <= w_href_p0;
      r_vsync_p2 <= r_vsync_p1;
      r_href_p2  <= r_href_p1;
      r_gray_p2  <= r_href_p1 ? mem_rd_data : '0;
    end
  end

  assign busy          = w_busy_fsm | r_vsync_p1 | r_vsync_p2;
  assign per_img_vsync = r_vsync_p2;
  assign per_img_href  = r_href_p2;
  assign per_img_gray  = r_gray_p2;

endmodule

// File: tb/tb_img_stream_src.sv
// Self-checking bench for img_stream_src on a 4x3 image: a frame-geometry model
// predicts every output per cycle from the stream's timing rules.
module tb_img_stream_src;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int HB  = 2;
  localparam int VT  = 2;
  localparam int GP  = 3;
  localparam int AW  = 19;
  localparam int PER = HB + W;
  localparam int L   = H * PER + VT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cont;
  logic          busy;
  logic          frame_done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          per_img_vsync;
  logic          per_img_href;
  logic [7:0]    per_img_gray;

  logic [7:0]    rom [0:15];
  int            fv0 [$];
  int            n_checks = 0;
  int            n_pass   = 0;

  typedef struct {
    bit         vs;
    bit         hr;
    logic [7:0] gray;
    bit         bsy;
    bit         done;
    bit         rd;
    int         addr;
  } exp_t;

  img_stream_src #(
    .C_IMG_WIDTH  (W),
    .C_IMG_HEIGHT (H),
    .C_H_BLANK    (HB),
    .C_V_TAIL     (VT),
    .C_FRAME_GAP  (GP),
    .C_ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cont          (cont),
    .busy          (busy),
    .frame_done    (frame_done),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .per_img_vsync (per_img_vsync),
    .per_img_href  (per_img_href),
    .per_img_gray  (per_img_gray)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rom[mem_rd_addr[3:0]];
  end

  // Cycle k counts clock periods from the cycle in which start is held high (k=0).
  // fv0 lists the cycles at which per_img_vsync rises for each frame of the run.
  function automatic exp_t model(int k);
    exp_t e = '{default: 0};
    int   d;
    if (fv0.size() > 0 && k >= fv0[0] - 2 && k < fv0[$] + L) e.bsy = 1;
    foreach (fv0[i]) begin
      d = k - fv0[i];
      if (d >= 0 && d < L) begin
        e.vs = 1;
        if (d / PER < H && d % PER >= HB) begin
          e.hr   = 1;
          e.gray = rom[(d / PER) * W + d % PER - HB];
        end
      end
      if (d + 2 >= 0 && d + 2 < L && (d + 2) / PER < H && (d + 2) % PER >= HB) begin
        e.rd   = 1;
        e.addr = ((d + 2) / PER) * W + (d + 2) % PER - HB;
      end
      if (d == L - 2) e.done = 1;
    end
    return e;
  endfunction

  // Packing: {vsync, href, gray[7:0], busy, frame_done, rd_en, addr (when rd_en)}.
  function automatic logic [31:0] obs_vec();
    return {per_img_vsync, per_img_href, per_img_gray, busy, frame_done, mem_rd_en,
            (mem_rd_en === 1'b1) ? mem_rd_addr : AW'(0)};
  endfunction

  function automatic logic [31:0] exp_vec(exp_t e);
    return {e.vs, e.hr, e.gray, e.bsy, e.done, e.rd, e.rd ? AW'(e.addr) : AW'(0)};
  endfunction

  function automatic logic [31:0] raw_vec();
    return {per_img_vsync, per_img_href, per_img_gray, busy, frame_done, mem_rd_en, mem_rd_addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rom_ramp();
    for (int i = 0; i < 16; i++) rom[i] = 8'(i + 16);
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    n_checks++;
    if (raw_vec() !== 32'h0) $display("FAIL reset_por got=%h want=%h", raw_vec(), 32'h0);
    else n_pass++;
    rst = 0;
    tick();
    tick();
    fv0 = {3};
    start = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      start = 0;
      e = model(k);
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL reset_run k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
    end
    rst = 1;
    #1;
    n_checks++;
    if (raw_vec() !== 32'h0) $display("FAIL reset_async got=%h want=%h", raw_vec(), 32'h0);
    else n_pass++;
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else n_pass++;
    n_checks++;
    if (mem_rd_en !== 1'b0) $display("FAIL reset_rden got=%b want=0", mem_rd_en);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    exp_t       e;
    logic [7:0] grays [$];
    int         n_done = 0;
    rom_ramp();
    cont  = 0;
    fv0   = {3};
    start = 1;
    for (int k = 1; k <= L + 8; k++) begin
      tick();
      start = 0;
      e = model(k);
      if (per_img_href === 1'b1) grays.push_back(per_img_gray);
      if (frame_done === 1'b1) n_done++;
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL single k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
    end
    n_checks++;
    if (grays.size() != W * H) $display("FAIL single_npix got=%0d want=%0d", grays.size(), W * H);
    else n_pass++;
    for (int i = 0; i < grays.size() && i < W * H; i++) begin
      n_checks++;
      if (grays[i] !== 8'(16 + i)) $display("FAIL single_gray i=%0d got=%h want=%h", i, grays[i], 8'(16 + i));
      else n_pass++;
    end
    n_checks++;
    if (n_done != 1) $display("FAIL single_done got=%0d want=1", n_done);
    else n_pass++;
    n_checks++;
    if (mem_rd_addr !== AW'(W * H - 1)) $display("FAIL single_addr_hold got=%0d want=%0d", mem_rd_addr, W * H - 1);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    rom_ramp();
    cont  = 0;
    fv0   = {3};
    start = 1;
    for (int k = 1; k <= L + 14; k++) begin
      tick();
      e = model(k);
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL ignore k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
      start = (k == 6 || k == 19) ? 1'b1 : 1'b0;
    end
    start = 0;
  endtask

  task automatic test_continuous();
    exp_t e;
    int   fall1 = -1;
    int   rise2 = -1;
    int   addr2 = -1;
    logic prev_vs = 1'b0;
    rom_ramp();
    cont = 1;
    fv0  = {3, 3 + L + GP + 1};
    start = 1;
    for (int k = 1; k <= fv0[1] + L + 8; k++) begin
      tick();
      start = 0;
      e = model(k);
      if (prev_vs === 1'b1 && per_img_vsync === 1'b0 && fall1 < 0) fall1 = k;
      if (prev_vs === 1'b0 && per_img_vsync === 1'b1 && fall1 >= 0 && rise2 < 0) rise2 = k;
      if (fall1 >= 0 && mem_rd_en === 1'b1 && addr2 < 0) addr2 = int'(mem_rd_addr);
      prev_vs = per_img_vsync;
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL cont k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
      if (k == fv0[1] + 5) cont = 0;
    end
    cont = 0;
    n_checks++;
    if (fall1 < 0 || rise2 - fall1 != 4) $display("FAIL cont_gap got=%0d want=4", rise2 - fall1);
    else n_pass++;
    n_checks++;
    if (addr2 != 0) $display("FAIL cont_addr_restart got=%0d want=0", addr2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    exp_t       e;
    logic [7:0] first_gray = 8'hxx;
    bit         seen = 0;
    rom_ramp();
    cont  = 0;
    fv0   = {3};
    start = 1;
    for (int k = 1; k <= 3 + HB + PER + 2; k++) begin
      tick();
      start = 0;
      e = model(k);
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL midrow k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
    end
    rst = 1;
    #1;
    n_checks++;
    if (raw_vec() !== 32'h0) $display("FAIL midrow_async got=%h want=%h", raw_vec(), 32'h0);
    else n_pass++;
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    start = 1;
    for (int k = 1; k <= L + 6; k++) begin
      tick();
      start = 0;
      e = model(k);
      if (per_img_href === 1'b1 && !seen) begin
        first_gray = per_img_gray;
        seen = 1;
      end
      n_checks++;
      if (obs_vec() !== exp_vec(e)) $display("FAIL restart k=%0d got=%h want=%h", k, obs_vec(), exp_vec(e));
      else n_pass++;
    end
    n_checks++;
    if (first_gray !== 8'h10) $display("FAIL restart_first got=%h want=10", first_gray);
    else n_pass++;
  endtask

  task automatic test_random();
    exp_t e;
    int   nfr;
    int   kdrop;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      nfr = $urandom_range(1, 3);
      fv0.delete();
      fv0.push_back(3);
      for (int f = 1; f < nfr; f++) fv0.push_back(fv0[f - 1] + L + GP + 1);
      kdrop = fv0[$] + $urandom_range(0, L - 4);
      cont  = (nfr > 1);
      start = 1;
      for (int k = 1; k <= fv0[$] + L + 6; k++) begin
        tick();
        e = model(k);
        n_checks++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL random it=%0d k=%0d got=%h want=%h", it, k, obs_vec(), exp_vec(e));
        else n_pass++;
        if (k == kdrop) cont = 0;
        start = (k <= fv0[$] + L - 3 && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      end
      start = 0;
      cont  = 0;
    end
  endtask

  initial begin
    rst   = 1;
    start = 0;
    cont  = 0;
    rom_ramp();
    test_reset();
    test_single_frame();
    test_start_ignored();
    test_continuous();
    test_reset_mid_row();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/img_stream_src.md
Name: img_stream_src

Overview:
- Frame-to-stream transmitter: reads a stored grey image from a synchronous single-port ROM/RAM read port.
- Emits it on the team's per_img_vsync/href/gray video interface, with the same frame timing the scaler's stimulus uses.
- Sits upstream of bilinear_interpolation (or any per_img_* consumer) and replaces bench-side pixel driving in hardware bring-up.

Parameters:
- C_IMG_WIDTH, 640, active pixels per row
- C_IMG_HEIGHT, 480, rows per frame
- C_H_BLANK, 5, href-low cycles before every row, including the first
- C_V_TAIL, 5, cycles after the last row's final pixel before vsync falls
- C_FRAME_GAP, 16, vsync-low idle cycles between frames in continuous mode
- C_ADDR_W, 19, read address width; must satisfy 2^C_ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins one frame when idle
- cont  in  1  level; when high at frame end, the next frame restarts automatically
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at the end of each frame
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  C_ADDR_W  pixel address, row-major (r*W+c)
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
- per_img_vsync  out  1  frame valid
- per_img_href  out  1  pixel valid
- per_img_gray  out  8  pixel value; 0 whenever href is low

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; counters 0.
- FSM states:
  - IDLE: start=1 -> HBLANK, row=0.
  - HBLANK: C_H_BLANK cycles -> ACTIVE.
  - ACTIVE: C_IMG_WIDTH cycles, mem_rd_en=1, addr increments by 1 per cycle. At the end, if row<H-1 -> HBLANK with row+1; else -> VTAIL.
  - VTAIL: C_V_TAIL cycles -> END.
  - END: one cycle; frame_done=1. If cont=1 -> GAP, else -> IDLE.
  - GAP: C_FRAME_GAP cycles -> HBLANK, row=0, addr=0.
- Internal timing: internal vsync is high in HBLANK, ACTIVE and VTAIL. Internal pre-href equals mem_rd_en.
- Output alignment: a 2-stage pipeline.
  - Stage 1 covers the ROM latency; stage 2 is the output register.
  - per_img_vsync and per_img_href are internal vsync and pre-href delayed 2 cycles.
  - per_img_gray is mem_rd_data registered once, gated to 0 when stage-1 href is low.
  - Net latency start -> per_img_vsync rise = 3 cycles (IDLE->HBLANK transition, then 2 pipeline cycles).
- Frame timing at the outputs, with V0 = the per_img_vsync rise cycle:
  - Row r, column c has href high at V0 + C_H_BLANK + r*(C_H_BLANK+C_IMG_WIDTH) + c.
  - per_img_vsync falls at V0 + H*(HB+W) + C_V_TAIL; default vsync-high length is 309605 cycles.
- Address generation: a linear counter with no multiplier. It resets to 0 at each frame start and ends at W*H-1. mem_rd_addr holds its last value when mem_rd_en=0.
- busy: 1 from the cycle after start is accepted through the cycle per_img_vsync falls, and throughout GAP. frame_done is the pulse in END; it is internal and is not delayed by the pipeline.
- start while busy: ignored, not queued.
- start and rst together: rst wins.
- rst mid-frame: outputs drop to 0 asynchronously. No partial frame resumes; the next start begins at pixel 0.
- cont deasserted during a frame: takes effect only at END, where it is sampled.

Decomposition:
- Package img_stream_pkg:
  - state enum typedef (IDLE, HBLANK, ACTIVE, VTAIL, END, GAP)
  - default geometry constants
  - function returning the frame cycle count for bench checks
- Sub-module img_stream_timing: FSM, row/column/blank counters and the address counter. Outputs internal vsync, pre-href, addr and frame_done.
- Top-level: instantiates img_stream_timing and adds the 2-stage alignment pipeline and gray gating.

Test Plan:
- Reset defaults: W=4, H=3, HB=2, VT=2, ROM data = addr+0x10; assert rst mid-run. All outputs are 0 immediately; after release, busy=0 and mem_rd_en=0.
- Single frame: start pulse at cycle 10.
  - vsync rises at cycle 13.
  - href bursts of 4 at offsets 2, 8, 14.
  - gray sequence 0x10..0x1B.
  - vsync falls at offset 20; frame_done pulses once; busy falls.
- Default geometry with the img_Gray1 ROM image: exactly 480 href bursts of 640 pixels, 5-cycle blanks, vsync high 309605 cycles. Pixels match the file byte-for-byte, and bilinear_interpolation downstream passes its existing result check.
- Start ignored while busy: start pulses during ACTIVE and VTAIL. Exactly one frame is produced and no frame follows.
- Continuous mode: cont=1 with GAP=3. Second vsync rise occurs 4 cycles after the first vsync fall (END + GAP), and addresses restart at 0. Deassert cont during frame 2 -> stop after frame 2.
- Reset mid-row: rst at row 1, column 2 -> outputs 0 at once. New start -> first pixel is addr 0 (gray 0x10).
